instr_line_fill: RTL and testbench

//  Line-fill engine between the L1 instruction cache miss port and the 32-bit main-memory read port.

---
 rtl/instr_line_fill_if.sv | 12 +
 rtl/instr_line_fill.sv | 114 +++++++++++
 tb/tb_instr_line_fill.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_line_fill_if.sv
// Main-memory word read port between the line-fill engine (master) and memory (slave).
// Requests issue on rd_req & rd_ready; responses return in issue order on rd_valid.
interface instr_line_fill_if;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (output rd_req, rd_addr, input rd_ready, rd_data, rd_valid);
    modport slave  (input rd_req, rd_addr, output rd_ready, rd_data, rd_valid);
endinterface

// File: rtl/instr_line_fill.sv
// I-cache line-fill engine: issues LINE_WORDS pipelined word reads, assembles the in-order
// responses into one line and returns it with a single fill_valid pulse (fill_error on timeout).
module instr_line_fill #(
    parameter int LINE_WORDS     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     fill_req,
    input  logic [31:0]              fill_addr,
    output logic [LINE_WORDS*32-1:0] fill_data,
    output logic                     fill_valid,
    output logic                     fill_error,
    output logic                     busy,
    instr_line_fill_if.master        mem
);
    localparam int CNT_W = $clog2(LINE_WORDS + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int OFF_W = $clog2(LINE_WORDS * 4);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] DONE    = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [31:0]      base;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] resp_cnt;
    logic [CNT_W-1:0] slot;
    logic [WD_W-1:0]  watchdog;
    logic [WD_W-1:0]  watchdog_next;
    logic             timed_out;
    logic             active;
    logic             issue_fire;
    logic             resp_fire;
    logic             last_issue;
    logic             last_resp;
    logic             timeout;

    assign active        = (state == ISSUE) || (state == WAIT);
    assign issue_fire    = (state == ISSUE) && mem.rd_ready;
    assign resp_fire     = active && mem.rd_valid && (resp_cnt < CNT_W'(LINE_WORDS));
    assign last_issue    = issue_fire && (issue_cnt == CNT_W'(LINE_WORDS - 1));
    assign last_resp     = resp_fire && (resp_cnt == CNT_W'(LINE_WORDS - 1));
    assign watchdog_next = watchdog + WD_W'(1);
    assign timeout       = active && !issue_fire && !resp_fire
                           && (watchdog_next == WD_W'(TIMEOUT_CYCLES));
    // Word 0 sits in the most significant slot of the line.
    assign slot          = CNT_W'(LINE_WORDS - 1) - resp_cnt;

    assign mem.rd_req  = (state == ISSUE);
    assign mem.rd_addr = base + {{(32 - CNT_W - 2){1'b0}}, issue_cnt, 2'b00};
    assign fill_valid  = (state == DONE);
    assign fill_error  = (state == DONE) && timed_out;
    assign busy        = (state != IDLE);

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (fill_req) state_next = ISSUE;
            ISSUE: begin
                if (last_resp || timeout) state_next = DONE;
                else if (last_issue)      state_next = WAIT;
            end
            WAIT:    if (last_resp || timeout) state_next = DONE;
            DONE:    state_next = RELEASE;
            RELEASE: if (!fill_req) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            base      <= '0;
            issue_cnt <= '0;
            resp_cnt  <= '0;
            watchdog  <= '0;
            timed_out <= 1'b0;
            // NOTE: the line buffer is reset too; its contents are visible on fill_data.
            fill_data <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state <= state_next;
            case (state)
                IDLE: begin
                    if (fill_req) begin
                        base      <= {fill_addr[31:OFF_W], {OFF_W{1'b0}}};
                        issue_cnt <= '0;
                        resp_cnt  <= '0;
                        watchdog  <= '0;
                        timed_out <= 1'b0;
                    end
                end
                ISSUE, WAIT: begin
                    if (issue_fire) issue_cnt <= issue_cnt + CNT_W'(1);
                    if (resp_fire) begin
                        fill_data[{slot, 5'b00000} +: 32] <= mem.rd_data;
                        resp_cnt <= resp_cnt + CNT_W'(1);
                    end
                    // Any progress on either side of the pipe restarts the watchdog.
                    if (issue_fire || resp_fire) watchdog <= '0;
                    else                         watchdog <= watchdog_next;
                    if (timeout) timed_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_line_fill.sv
// Directed bench for instr_line_fill: in-order memory responder model with configurable
// ready pattern, latency and response budget; immediate-assertion checks per step.
module tb_instr_line_fill;
    logic         CLK = 1'b0;
    logic         RESET;
    logic         fill_req;
    logic [31:0]  fill_addr;
    logic [255:0] fill_data;
    logic         fill_valid;
    logic         fill_error;
    logic         busy;

    instr_line_fill_if mem_if ();

    instr_line_fill #(.LINE_WORDS(8), .TIMEOUT_CYCLES(16)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .fill_valid (fill_valid),
        .fill_error (fill_error),
        .busy       (busy),
        .mem        (mem_if)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int fv_count = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        #1;
        if (fill_valid) fv_count <= fv_count + 1;
    end

    // Memory responder model
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] issued[$];
    int          rdy_mode       = 0;
    bit          rdy_phase      = 1'b0;
    int          lat            = 1;
    logic [31:0] salt           = '0;
    int          resp_budget    = 1000;
    bit          inject         = 1'b0;
    logic [31:0] inject_data    = '0;
    int          last_resp_edge = 0;
    int          last_issue_edge = 0;

    always @(negedge CLK) begin
        case (rdy_mode)
            0: mem_if.rd_ready = 1'b1;
            1: begin
                mem_if.rd_ready = ~rdy_phase;
                rdy_phase       = ~rdy_phase;
            end
            default: mem_if.rd_ready = 1'b0;
        endcase
        if (mem_if.rd_req && mem_if.rd_ready) begin
            pend.push_back('{addr: mem_if.rd_addr, due: cyc + 1 + lat});
            issued.push_back(mem_if.rd_addr);
            last_issue_edge = cyc + 1;
        end
        mem_if.rd_valid = 1'b0;
        mem_if.rd_data  = '0;
        if (inject) begin
            mem_if.rd_valid = 1'b1;
            mem_if.rd_data  = inject_data;
            inject          = 1'b0;
        end else if (pend.size() > 0 && resp_budget > 0) begin
            if (pend[0].due == cyc + 1) begin
                mem_if.rd_valid = 1'b1;
                mem_if.rd_data  = pend[0].addr ^ salt;
                void'(pend.pop_front());
                resp_budget     = resp_budget - 1;
                last_resp_edge  = cyc + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] b, input logic [31:0] s);
        logic [255:0] l;
        l = '0;
        for (int k = 0; k < 8; k++) l[255 - 32*k -: 32] = (b + 32'(4*k)) ^ s;
        return l;
    endfunction

    task automatic wait_fill(input string tag, input int budget, output int at_cyc);
        bit found;
        found  = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge CLK);
            if (fill_valid) begin
                found  = 1'b1;
                at_cyc = cyc;
            end
        end
        check({tag, " fill_valid seen"}, 256'(found), 256'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] exp_line;
        logic [255:0] old_line;
        int           at;
        int           fv_base;
        int           last_act;

        RESET     = 1'b0;
        fill_req  = 1'b0;
        fill_addr = '0;

        // Reset state
        repeat (2) @(negedge CLK);
        check("rst fill_data", fill_data, '0);
        check("rst fill_valid", fill_valid, 0);
        check("rst fill_error", fill_error, 0);
        check("rst busy", busy, 0);
        check("rst mem_rd_req", mem_if.rd_req, 0);
        check("rst mem_rd_addr", mem_if.rd_addr, 0);
        RESET = 1'b1;

        // T1: ready=1, L=1, exact issue addresses and fill_valid cycle
        @(posedge CLK);
        rdy_mode = 0; lat = 1; salt = 32'hA5A5_0000; resp_budget = 1000;
        issued.delete(); pend.delete();
        @(negedge CLK);
        fill_req  = 1'b1;
        fill_addr = 32'h0000_1234;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            check($sformatf("t1 req c%0d", k), mem_if.rd_req, 256'(k <= 8));
            if (k <= 8)
                check($sformatf("t1 addr c%0d", k), mem_if.rd_addr, 32'h0000_1220 + 32'(4*(k-1)));
            check($sformatf("t1 fill_valid c%0d", k), fill_valid, 256'(k == 10));
            if (k == 1) check("t1 busy", busy, 1);
            if (k == 10) begin
                check("t1 fill_error", fill_error, 0);
                check("t1 fill_data", fill_data, make_line(32'h0000_1220, 32'hA5A5_0000));
                fill_req = 1'b0;
            end
        end
        check("t1 idle after release", busy, 0);
        check("t1 pulse count", fv_count, 1);

        // T2: toggling ready, L=3, data=addr, fill_addr changes mid-fill
        @(posedge CLK);
        rdy_mode = 1; rdy_phase = 1'b0; lat = 3; salt = '0;
        issued.delete();
        fv_base = fv_count;
        @(negedge CLK);
        fill_req  = 1'b1;
        fill_addr = 32'h8000_2F0C;
        repeat (3) @(negedge CLK);
        fill_addr = 32'hDEAD_BEEF;
        wait_fill("t2", 80, at);
        check("t2 issue count", issued.size(), 8);
        for (int k = 0; k < 8 && k < issued.size(); k++)
            check($sformatf("t2 issue addr %0d", k), issued[k], 32'h8000_2F00 + 32'(4*k));
        old_line = make_line(32'h8000_2F00, '0);
        check("t2 fill_data", fill_data, old_line);
        check("t2 fill_error", fill_error, 0);

        // T3: fill_req held high 3 cycles after fill_valid
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            check($sformatf("t3 busy hold %0d", k), busy, 1);
            check($sformatf("t3 no req %0d", k), mem_if.rd_req, 0);
        end
        fill_req = 1'b0;
        @(negedge CLK);
        check("t3 idle", busy, 0);
        check("t3 no req after drop", mem_if.rd_req, 0);
        check("t3 single pulse", fv_count - fv_base, 1);
        check("t3 data held", fill_data, old_line);

        // T4: memory stops after 5 responses, watchdog timeout
        @(posedge CLK);
        rdy_mode = 0; lat = 4; salt = 32'h1111_0000; resp_budget = 5;
        pend.delete(); issued.delete();
        @(negedge CLK);
        fill_req  = 1'b1;
        fill_addr = 32'h0000_4010;
        wait_fill("t4", 80, at);
        check("t4 fill_error", fill_error, 1);
        last_act = (last_resp_edge > last_issue_edge) ? last_resp_edge : last_issue_edge;
        check("t4 timeout distance", 256'(at - last_act), 256'(16));
        exp_line = old_line;
        for (int k = 0; k < 5; k++)
            exp_line[255 - 32*k -: 32] = (32'h0000_4000 + 32'(4*k)) ^ 32'h1111_0000;
        check("t4 fill_data partial", fill_data, exp_line);
        fill_req = 1'b0;
        @(negedge CLK);
        check("t4 fill_error pulse", fill_error, 0);
        check("t4 fill_valid pulse", fill_valid, 0);

        // T5: reset in WAIT with 3 responses pending
        @(posedge CLK);
        pend.delete(); lat = 4; salt = 32'h5555_0000; resp_budget = 1000;
        @(negedge CLK);
        fill_req  = 1'b1;
        fill_addr = 32'h0000_6004;
        repeat (10) @(negedge CLK);
        check("t5 in wait busy", busy, 1);
        check("t5 in wait no req", mem_if.rd_req, 0);
        check("t5 pending", pend.size(), 3);
        fv_base = fv_count;
        fill_req = 1'b0;
        RESET    = 1'b0;
        #1;
        check("t5 async fill_data", fill_data, '0);
        check("t5 async busy", busy, 0);
        check("t5 async req", mem_if.rd_req, 0);
        check("t5 async addr", mem_if.rd_addr, 0);
        check("t5 async valid", fill_valid, 0);
        @(negedge CLK);
        RESET = 1'b1;
        repeat (4) @(negedge CLK);
        check("t5 late resp ignored data", fill_data, '0);
        check("t5 late resp ignored busy", busy, 0);
        check("t5 no pulse", fv_count - fv_base, 0);
        @(posedge CLK);
        lat = 2; salt = 32'h6666_0000;
        @(negedge CLK);
        fill_req  = 1'b1;
        fill_addr = 32'h0000_703C;
        wait_fill("t5b", 60, at);
        old_line = make_line(32'h0000_7020, 32'h6666_0000);
        check("t5b fill_data", fill_data, old_line);
        fill_req = 1'b0;
        repeat (3) @(negedge CLK);

        // T6: stray valid in IDLE, then 9th/10th responses after completion
        @(posedge CLK);
        inject_data = 32'hBAD0_0001; inject = 1'b1;
        repeat (3) @(negedge CLK);
        check("t6 idle stray data", fill_data, old_line);
        check("t6 idle stray busy", busy, 0);
        @(posedge CLK);
        rdy_mode = 0; lat = 1; salt = 32'h7777_0000; pend.delete();
        fv_base = fv_count;
        @(negedge CLK);
        fill_req  = 1'b1;
        fill_addr = 32'h0000_9000;
        repeat (9) @(negedge CLK);
        @(posedge CLK);
        inject_data = 32'hBAD0_0009; inject = 1'b1;
        @(negedge CLK);
        check("t6 fill_valid c10", fill_valid, 1);
        @(posedge CLK);
        inject_data = 32'hBAD0_000A; inject = 1'b1;
        @(negedge CLK);
        check("t6 release busy", busy, 1);
        fill_req = 1'b0;
        repeat (2) @(negedge CLK);
        check("t6 fill_data", fill_data, make_line(32'h0000_9000, 32'h7777_0000));
        check("t6 idle", busy, 0);
        check("t6 single pulse", fv_count - fv_base, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
